multicycle_controller: RTL and testbench

Main control unit for the RISC-V multicycle core. It sits directly upstream of the datapath: it consumes `Instr` and `Zero` from the datapath and drives every datapath control input, plus `MemWrite` to the unified memory. A Moore state machine sequences fetch, decode, execute, memory and writeback. A combinational ALU decoder and an immediate-format decoder are folded into the same block.

---
 rtl/multicycle_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Main control unit of the RISC-V multicycle core. A Moore state machine
// sequences FETCH / DECODE / MEMADR / MEMREAD / MEMWB / MEMWRITE / EXECUTER /
// EXECUTEI / ALUWB / BRANCH / JAL. The ALU decoder and the immediate-format
// decoder are folded in as combinational logic.
//
// Optional feature: define RV_BNE_EN to accept branch funct3 001 (bne).
// Without it only beq (funct3 000) is a legal branch; anything else takes the
// illegal path (DECODE -> FETCH with Illegal=1).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   Instr      in   instruction register ([6:0], [14:12], [30] are used)
//   Zero       in   ALU zero flag
//   PCWrite    out  PC enable (in BRANCH: branch taken, combinational on Zero)
//   AdrSrc     out  memory address select (0 = PC, 1 = Result)
//   MemWrite   out  memory write strobe
//   IRWrite    out  instruction register / OldPC enable
//   ResultSrc  out  Result select (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUControl out  ALU op (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   ALUSrcA    out  SrcA select (00 PC, 01 OldPC, 10 A)
//   ALUSrcB    out  SrcB select (00 WriteData, 01 ImmExt, 10 const 4)
//   ImmSrc     out  immediate format (00 I, 01 S, 10 B, 11 J)
//   RegWrite   out  register file write enable
//   Illegal    out  one-cycle pulse in DECODE for unsupported opcode/funct3
//   dbg_state  out  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic        RegWrite,
  output logic        Illegal,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_ok;
  logic       branch_taken;
  logic [2:0] alu_dec;

  // Raw enables before the reset gate.
  logic pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

  assign opcode    = Instr[6:0];
  assign funct3    = Instr[14:12];
  assign dbg_state = state_q;

  // Supported branch kinds and their taken condition.
  always_comb begin
    branch_ok    = 1'b0;
    branch_taken = 1'b0;
`ifdef RV_BNE_EN
    branch_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
    branch_taken = (funct3 == 3'b001) ? ~Zero : Zero;
`else
    branch_ok    = (funct3 == 3'b000);
    branch_taken = Zero;
`endif
  end

  // ALU decoder; only sub needs Instr[30], and only for R-type (addi with a
  // negative immediate can have bit 30 set and must stay add).
  always_comb begin
    alu_dec = 3'b000;
    case (funct3)
      3'b000:  alu_dec = ((opcode == OP_R) && Instr[30]) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  end

  // Immediate format depends only on the opcode, in every state.
  always_comb begin
    ImmSrc = 2'b00;
    case (opcode)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BR:       ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BR:        state_d = branch_ok ? S_BRANCH : S_FETCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register: the only storage in the block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Moore output decode.
  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUControl    = 3'b000;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b01;
        // Illegal exactly when DECODE falls back to FETCH.
        illegal_raw = (state_d == S_FETCH);
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUControl   = 3'b001;
        pc_write_raw = branch_taken;
      end
      S_JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are held low for the whole time reset is asserted; the state is
  // already FETCH then, so the remaining outputs show FETCH values.
  assign PCWrite  = pc_write_raw  & reset;
  assign MemWrite = mem_write_raw & reset;
  assign IRWrite  = ir_write_raw  & reset;
  assign RegWrite = reg_write_raw & reset;
  assign Illegal  = illegal_raw   & reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Per-cycle expected control vectors are pushed to exp_q when an instruction
// is driven and popped/compared on each falling edge while the DUT walks
// through its states. Vector layout (21 bits):
//   {state[3:0], PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc[1:0],
//    ALUControl[2:0], ALUSrcA[1:0], ALUSrcB[1:0], ImmSrc[1:0], RegWrite,
//    Illegal}
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam int W = 21;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic [W-1:0] obs_v;
  int           n_cmp;
  int           n_mis;
  int           cyc;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .Illegal    (Illegal),
    .dbg_state  (dbg_state)
  );

  assign obs_v = {dbg_state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                  ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegWrite, Illegal};

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-vector builders
  function automatic logic [W-1:0] mk(input logic [3:0] st,
                                      input logic pcw, input logic adr,
                                      input logic mw, input logic irw,
                                      input logic [1:0] rs, input logic [2:0] alu,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] imm,
                                      input logic rw, input logic ill);
    return {st, pcw, adr, mw, irw, rs, alu, sa, sb, imm, rw, ill};
  endfunction

  function automatic logic [W-1:0] v_fetch(input logic [1:0] imm);
    return mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 2'b00, 2'b10, imm, 1'b0, 1'b0);
  endfunction

  function automatic logic [W-1:0] v_decode(input logic [1:0] imm, input logic ill);
    return mk(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b01, 2'b01, imm, 1'b0, ill);
  endfunction

  // FETCH values with all enables held low
  function automatic logic [W-1:0] v_in_reset(input logic [1:0] imm);
    return mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, 2'b00, 2'b10, imm, 1'b0, 1'b0);
  endfunction

  // Driver task: set inputs at a falling edge
  task automatic drive(input logic [31:0] instr, input logic zero);
    Instr = instr;
    Zero  = zero;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(32'h0000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (obs_v !== v_in_reset(2'b00)) begin
        n_mis++;
        $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs_v, v_in_reset(2'b00));
      end
    end
    @(negedge clk);
    reset = 1'b1;
    // Instr=0 is an unsupported opcode, so this returns to FETCH.
    exp_q.push_back(v_fetch(2'b00));
    exp_q.push_back(v_decode(2'b00, 1'b1));
    cyc = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      #1;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL reset_release cyc%0d: got %h want %h", cyc, obs_v, exp_v);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    drive(32'h0045_2283, 1'($urandom_range(0, 1)));
    exp_q.push_back(v_fetch(2'b00));
    exp_q.push_back(v_decode(2'b00, 1'b0));
    exp_q.push_back(mk(4'd2, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 2'b00, 0, 0));
    exp_q.push_back(mk(4'd3, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0));
    exp_q.push_back(mk(4'd4, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0));
    cyc = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      #1;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL lw cyc%0d: got %h want %h", cyc, obs_v, exp_v);
      end
      cyc++;
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (obs_v !== v_fetch(2'b00)) begin
      n_mis++;
      $display("FAIL lw_latency: got %h want %h", obs_v, v_fetch(2'b00));
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] tab_i[7];
    logic [2:0]  tab_alu[7];
    logic        tab_r[7];
    tab_i[0] = 32'h4020_8133; tab_alu[0] = 3'b001; tab_r[0] = 1'b1; // sub
    tab_i[1] = 32'h0020_8133; tab_alu[1] = 3'b000; tab_r[1] = 1'b1; // add
    tab_i[2] = 32'h0020_A033; tab_alu[2] = 3'b101; tab_r[2] = 1'b1; // slt
    tab_i[3] = 32'h0020_F033; tab_alu[3] = 3'b010; tab_r[3] = 1'b1; // and
    tab_i[4] = 32'h0020_9033; tab_alu[4] = 3'b000; tab_r[4] = 1'b1; // sll -> add
    tab_i[5] = 32'h0062_E293; tab_alu[5] = 3'b011; tab_r[5] = 1'b0; // ori
    tab_i[6] = 32'h4000_0013; tab_alu[6] = 3'b000; tab_r[6] = 1'b0; // addi, bit30 set
    for (int k = 0; k < 7; k++) begin
      drive(tab_i[k], 1'($urandom_range(0, 1)));
      exp_q.push_back(v_fetch(2'b00));
      exp_q.push_back(v_decode(2'b00, 1'b0));
      if (tab_r[k])
        exp_q.push_back(mk(4'd6, 0, 0, 0, 0, 2'b00, tab_alu[k], 2'b10, 2'b00, 2'b00, 0, 0));
      else
        exp_q.push_back(mk(4'd7, 0, 0, 0, 0, 2'b00, tab_alu[k], 2'b10, 2'b01, 2'b00, 0, 0));
      exp_q.push_back(mk(4'd8, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0));
      cyc = 0;
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        #1;
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_mis++;
          $display("FAIL alu_op%0d cyc%0d: got %h want %h", k, cyc, obs_v, exp_v);
        end
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jal();
    drive(32'h0080_00EF, 1'($urandom_range(0, 1)));
    exp_q.push_back(v_fetch(2'b11));
    exp_q.push_back(v_decode(2'b11, 1'b0));
    exp_q.push_back(mk(4'd10, 1, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 2'b11, 0, 0));
    exp_q.push_back(mk(4'd8, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b11, 1, 0));
    cyc = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      #1;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL jal cyc%0d: got %h want %h", cyc, obs_v, exp_v);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      drive(32'h0000_0463, 1'(z));
      exp_q.push_back(v_fetch(2'b10));
      exp_q.push_back(v_decode(2'b10, 1'b0));
      exp_q.push_back(mk(4'd9, 1'(z), 0, 0, 0, 2'b00, 3'b001, 2'b10, 2'b00, 2'b10, 0, 0));
      cyc = 0;
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        #1;
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_mis++;
          $display("FAIL beq_z%0d cyc%0d: got %h want %h", z, cyc, obs_v, exp_v);
        end
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_bne();
    for (int z = 0; z < 2; z++) begin
      drive(32'h0000_1463, 1'(z));
      exp_q.push_back(v_fetch(2'b10));
`ifdef RV_BNE_EN
      exp_q.push_back(v_decode(2'b10, 1'b0));
      exp_q.push_back(mk(4'd9, 1'(z == 0), 0, 0, 0, 2'b00, 3'b001, 2'b10, 2'b00, 2'b10, 0, 0));
`else
      exp_q.push_back(v_decode(2'b10, 1'b1));
`endif
      cyc = 0;
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        #1;
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_mis++;
          $display("FAIL bne_z%0d cyc%0d: got %h want %h", z, cyc, obs_v, exp_v);
        end
        cyc++;
        @(negedge clk);
      end
      #1;
      n_cmp++;
      if (obs_v !== v_fetch(2'b10)) begin
        n_mis++;
        $display("FAIL bne_next z%0d: got %h want %h", z, obs_v, v_fetch(2'b10));
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad_i[2];
    logic [1:0]  bad_imm[2];
    bad_i[0] = 32'h0000_007F; bad_imm[0] = 2'b00; // unsupported opcode
    bad_i[1] = 32'h0000_2463; bad_imm[1] = 2'b10; // branch funct3 010
    for (int k = 0; k < 2; k++) begin
      drive(bad_i[k], 1'($urandom_range(0, 1)));
      exp_q.push_back(v_fetch(bad_imm[k]));
      exp_q.push_back(v_decode(bad_imm[k], 1'b1));
      cyc = 0;
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        #1;
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_mis++;
          $display("FAIL illegal%0d cyc%0d: got %h want %h", k, cyc, obs_v, exp_v);
        end
        cyc++;
        @(negedge clk);
      end
      // Back in FETCH with Illegal already low: a one-cycle pulse.
      #1;
      n_cmp++;
      if (obs_v !== v_fetch(bad_imm[k])) begin
        n_mis++;
        $display("FAIL illegal%0d_next: got %h want %h", k, obs_v, v_fetch(bad_imm[k]));
      end
    end
  endtask

  task automatic test_reset_mid_sw();
    logic [W-1:0] memwrite_v;
    memwrite_v = mk(4'd5, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 0, 0);
    drive(32'h0052_A223, 1'($urandom_range(0, 1)));
    exp_q.push_back(v_fetch(2'b01));
    exp_q.push_back(v_decode(2'b01, 1'b0));
    exp_q.push_back(mk(4'd2, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 2'b01, 0, 0));
    cyc = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      #1;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL sw_pre cyc%0d: got %h want %h", cyc, obs_v, exp_v);
      end
      cyc++;
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if (obs_v !== memwrite_v) begin
      n_mis++;
      $display("FAIL sw_memwrite: got %h want %h", obs_v, memwrite_v);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs_v !== v_in_reset(2'b01)) begin
      n_mis++;
      $display("FAIL sw_reset_now: got %h want %h", obs_v, v_in_reset(2'b01));
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (obs_v !== v_in_reset(2'b01)) begin
      n_mis++;
      $display("FAIL sw_reset_hold: got %h want %h", obs_v, v_in_reset(2'b01));
    end
    reset = 1'b1;
    // Full sw after recovery.
    exp_q.push_back(v_fetch(2'b01));
    exp_q.push_back(v_decode(2'b01, 1'b0));
    exp_q.push_back(mk(4'd2, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 2'b01, 2'b01, 0, 0));
    exp_q.push_back(memwrite_v);
    exp_q.push_back(v_fetch(2'b01));
    cyc = 0;
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      #1;
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_mis++;
        $display("FAIL sw_full cyc%0d: got %h want %h", cyc, obs_v, exp_v);
      end
      cyc++;
      if (exp_q.size() > 0) @(negedge clk);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    cyc   = 0;
    reset = 1'b0;
    Instr = 32'h0;
    Zero  = 1'b0;
    test_reset();
    test_lw();
    test_alu_ops();
    test_jal();
    test_beq();
    test_bne();
    test_illegal();
    test_reset_mid_sw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
